// File: rtl/u01_sched_pkg.sv
// Shared types and constants for the U01 sample scheduler: FSM states,
// seed/sample widths, fallback seed and the requester-index width helper.
package u01_sched_pkg;

    localparam int SEED_W   = 23;
    localparam int SAMPLE_W = 32;

    // A zero seed would lock the core's generator, so this one is used instead.
    localparam logic [SEED_W-1:0] DEFAULT_SEED = 23'd232;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_CORE = 3'd1,
        ST_LOAD       = 3'd2,
        ST_WARMUP     = 3'd3,
        ST_RUN        = 3'd4
    } sched_state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among NREQ requesters. Scanning starts one past the
// last winner; the pointer only advances on an enabled, successful pick.
module rr_arbiter
    import u01_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic                  upd_en,
    output logic                  any_req,
    output logic [id_w(NREQ)-1:0] win
);

    localparam int IDW = id_w(NREQ);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] cand;

    always_comb begin
        any_req = 1'b0;
        win     = ptr_q;
        cand    = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_en && any_req) begin
            ptr_d = win;
        end
    end

    // Starting at NREQ-1 gives requester 0 first priority after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= IDW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/u01_scheduler.sv
// Brings up the shared U01 core (reset, seed load, warm-up discard) and then
// hands each new sample to one requester per cycle through a round-robin grant.
module u01_scheduler
    import u01_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int RST_CYCLES = 3,
    parameter int WARMUP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SEED_W-1:0]     seed_in,
    output logic                  busy,
    output logic                  running,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       gnt,
    output logic                  sample_valid,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic [id_w(NREQ)-1:0] sample_id,
    output logic [15:0]           dropped_cnt,
    output logic                  u01_rst,
    output logic                  u01_en,
    output logic [SEED_W-1:0]     u01_seed,
    input  logic [SAMPLE_W-1:0]   u01_sample
);

    localparam int IDW   = id_w(NREQ);
    localparam int CNT_W = 8;

    sched_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [15:0]         drop_q, drop_d;

    logic                arb_en;
    logic                arb_any;
    logic [IDW-1:0]      arb_win;

    // A start pulse in the same cycle pre-empts arbitration.
    assign arb_en = (state_q == ST_RUN) && !start;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .upd_en  (arb_en),
        .any_req (arb_any),
        .win     (arb_win)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        if (start) begin
            state_d = ST_RESET_CORE;
            cnt_d   = '0;
            seed_d  = (seed_in == '0) ? DEFAULT_SEED : seed_in;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RESET_CORE: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                    cnt_d   = '0;
                end
                ST_WARMUP: begin
                    if (cnt_q == CNT_W'(WARMUP - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Every RUN edge consumes one core sample: it is either granted or dropped.
    always_comb begin
        gnt_d    = '0;
        id_d     = id_q;
        sample_d = sample_q;
        drop_d   = drop_q;
        if (start) begin
            drop_d = '0;
        end else if (arb_en) begin
            if (arb_any) begin
                gnt_d    = NREQ'(1) << arb_win;
                id_d     = arb_win;
                sample_d = u01_sample;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            seed_q   <= '0;
            gnt_q    <= '0;
            id_q     <= '0;
            sample_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seed_q   <= seed_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
            sample_q <= sample_d;
            drop_q   <= drop_d;
        end
    end

    assign busy         = (state_q == ST_RESET_CORE) || (state_q == ST_LOAD) ||
                          (state_q == ST_WARMUP);
    assign running      = (state_q == ST_RUN);
    assign gnt          = gnt_q;
    assign sample_valid = |gnt_q;
    assign sample_out   = sample_q;
    assign sample_id    = id_q;
    assign dropped_cnt  = drop_q;
    assign u01_rst      = (state_q == ST_RESET_CORE);
    assign u01_en       = (state_q == ST_LOAD);
    assign u01_seed     = (state_q == ST_LOAD) ? seed_q : '0;

endmodule

// File: tb/tb_u01_scheduler.sv
// Directed bench for u01_scheduler with a small LFSR stand-in for the U01 core
// and a cycle-timeline reference model checked on every falling edge.
module tb_u01_scheduler;

    localparam int NREQ       = 4;
    localparam int RST_CYCLES = 3;
    localparam int WARMUP     = 2;
    localparam int RUN_AT     = RST_CYCLES + WARMUP + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [22:0] seed_in = '0;
    logic [3:0]  req = '0;
    logic        busy, running, sample_valid, u01_rst, u01_en;
    logic [3:0]  gnt;
    logic [31:0] sample_out, u01_sample;
    logic [1:0]  sample_id;
    logic [15:0] dropped_cnt;
    logic [22:0] u01_seed;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    u01_scheduler #(
        .NREQ       (NREQ),
        .RST_CYCLES (RST_CYCLES),
        .WARMUP     (WARMUP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed_in      (seed_in),
        .busy         (busy),
        .running      (running),
        .req          (req),
        .gnt          (gnt),
        .sample_valid (sample_valid),
        .sample_out   (sample_out),
        .sample_id    (sample_id),
        .dropped_cnt  (dropped_cnt),
        .u01_rst      (u01_rst),
        .u01_en       (u01_en),
        .u01_seed     (u01_seed),
        .u01_sample   (u01_sample)
    );

    function automatic logic [22:0] lfsr_next(input logic [22:0] s);
        return {s[21:0], s[22] ^ s[17]};
    endfunction

    function automatic logic [31:0] to_float(input logic [22:0] s);
        return {1'b0, 8'd126, s};
    endfunction

    function automatic logic [31:0] ref_sample(input logic [22:0] seed, input int k);
        logic [22:0] s;
        s = seed;
        for (int i = 0; i < k; i++) s = lfsr_next(s);
        return to_float(s);
    endfunction

    // Core stand-in: new value every cycle, seed loaded on u01_en.
    logic [22:0] core_q = '0;
    always @(posedge clk) begin
        if (u01_rst)     core_q <= '0;
        else if (u01_en) core_q <= u01_seed;
        else             core_q <= lfsr_next(core_q);
    end
    assign u01_sample = to_float(core_q);

    // Reference model: m_k counts cycles since the accepted start (0 = idle).
    int          m_k = 0;
    logic [22:0] m_seed = '0;
    int          m_ptr = NREQ - 1;
    logic [3:0]  m_gnt = '0;
    int          m_id = 0;
    logic [31:0] m_sample = '0;
    int          m_drop = 0;
    int          m_idx = 0;

    always @(posedge clk or negedge rst) begin : model_blk
        int  win;
        int  j;
        bit  arb;
        if (!rst) begin
            m_k = 0; m_seed = '0; m_ptr = NREQ - 1; m_gnt = '0;
            m_id = 0; m_sample = '0; m_drop = 0; m_idx = 0;
        end else begin
            arb   = (m_k == RUN_AT) && !start;
            m_gnt = '0;
            if (arb) begin
                win = -1;
                for (int i = 1; i <= NREQ; i++) begin
                    j = (m_ptr + i) % NREQ;
                    if (win < 0 && req[j]) win = j;
                end
                if (win >= 0) begin
                    m_gnt    = 4'(1 << win);
                    m_id     = win;
                    m_sample = ref_sample(m_seed, WARMUP + m_idx);
                    m_ptr    = win;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
                m_idx++;
            end
            if (start) begin
                m_k    = 1;
                m_seed = (seed_in == 23'd0) ? 23'd232 : seed_in;
                m_drop = 0;
                m_idx  = 0;
            end else if (m_k > 0 && m_k < RUN_AT) begin
                m_k++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy",         32'(busy),        32'(m_k >= 1 && m_k < RUN_AT));
        check("running",      32'(running),     32'(m_k == RUN_AT));
        check("u01_rst",      32'(u01_rst),     32'(m_k >= 1 && m_k <= RST_CYCLES));
        check("u01_en",       32'(u01_en),      32'(m_k == RST_CYCLES + 1));
        check("u01_seed",     32'(u01_seed),    (m_k == RST_CYCLES + 1) ? 32'(m_seed) : 32'd0);
        check("gnt",          32'(gnt),         32'(m_gnt));
        check("sample_valid", 32'(sample_valid), 32'(m_gnt != 4'd0));
        check("sample_out",   sample_out,       m_sample);
        check("dropped_cnt",  32'(dropped_cnt), 32'(m_drop));
        if (m_gnt != 4'd0) check("sample_id", 32'(sample_id), 32'(m_id));
        if (u01_en) check("load_seed_nonzero", 32'(u01_seed != 23'd0), 32'd1);
        if (gnt != 4'd0)
            $display("grant t=%0t gnt=%b id=%0d sample=%h dropped=%0d",
                     $time, gnt, sample_id, sample_out, dropped_cnt);
    end

    task automatic step(input logic [3:0] r);
        @(posedge clk); #1;
        req = r;
        @(negedge clk);
    endtask

    // Pulses start, then measures the bring-up; returns on the first RUN cycle.
    task automatic bringup(input logic [22:0] s, input logic [22:0] exp_seed,
                           input logic [3:0] new_req);
        int n_rst, n_en, load_c, run_c;
        logic [22:0] ld_seed;
        n_rst = 0; n_en = 0; load_c = -1; run_c = -1; ld_seed = '0;
        @(posedge clk); #1;
        start = 1'b1; seed_in = s; req = new_req;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_gnt_clear",  32'(gnt),         32'd0);
        check("start_drop_clear", 32'(dropped_cnt), 32'd0);
        for (int c = 0; c < 40; c++) begin
            if (u01_rst) n_rst++;
            if (u01_en) begin
                n_en++;
                load_c  = c;
                ld_seed = u01_seed;
            end
            if (running) begin
                run_c = c;
                break;
            end
            @(negedge clk);
        end
        if (run_c < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_timeout: running never rose within 40 cycles");
        end
        check("rst_pulse_len",  32'(n_rst),        32'(RST_CYCLES));
        check("load_strobes",   32'(n_en),         32'd1);
        check("load_seed",      32'(ld_seed),      32'(exp_seed));
        check("run_after_load", 32'(run_c - load_c), 32'(WARMUP + 1));
    endtask

    logic [3:0] exp_rr [8];

    initial begin
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_running", 32'(running),     32'd0);
        check("rst_gnt",     32'(gnt),         32'd0);
        check("rst_sample",  sample_out,       32'd0);
        check("rst_id",      32'(sample_id),   32'd0);
        check("rst_drop",    32'(dropped_cnt), 32'd0);
        check("rst_core",    32'({u01_rst, u01_en, u01_seed}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Bring-up with explicit seed, then a few unclaimed RUN cycles.
        bringup(23'd232, 23'd232, 4'b0000);
        repeat (3) step(4'b0000);

        // Zero seed falls back to 232; all requesters asserted from bring-up.
        bringup(23'd0, 23'd232, 4'b1111);
        for (int i = 0; i < 8; i++) begin
            step((i == 7) ? 4'b0100 : 4'b1111);
            check("rr_gnt", 32'(gnt), 32'(exp_rr[i]));
            check("rr_valid", 32'(sample_valid), 32'd1);
            if (i == 0) check("rr_first_sample", sample_out, 32'h3F0003A0);
        end

        // Single requester, then idle cycles that drop samples.
        for (int i = 0; i < 3; i++) begin
            step((i == 2) ? 4'b0000 : 4'b0100);
            check("sparse_gnt", 32'(gnt), 32'h4);
        end
        for (int i = 0; i < 5; i++) begin
            step((i == 4) ? 4'b1111 : 4'b0000);
            check("idle_gnt", 32'(gnt), 32'd0);
        end
        check("idle_dropped", 32'(dropped_cnt), 32'd5);
        step(4'b1111);
        check("rr_resume_gnt", 32'(gnt), 32'h8);

        // Restart mid-RUN with seed 77 while everyone requests.
        bringup(23'd77, 23'd77, 4'b1111);
        step(4'b1111);
        check("restart_gnt",    32'(gnt), 32'h2);
        check("restart_sample", sample_out, 32'h3F000134);
        step(4'b1010);
        step(4'b0011);
        step(4'b0000);
        step(4'b1001);
        repeat (3) step(4'b1111);

        // Async reset in the middle of WARMUP.
        @(posedge clk); #1;
        start = 1'b1; seed_in = 23'd5;
        @(posedge clk); #1;
        start = 1'b0;
        begin : wait_load
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (u01_en) seen = 1'b1;
            end
            if (!seen) begin
                n_checks++;
                n_errors++;
                $display("FAIL load_timeout: u01_en never seen within 20 cycles");
            end
        end
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("arst_busy",    32'(busy),         32'd0);
        check("arst_running", 32'(running),      32'd0);
        check("arst_gnt",     32'(gnt),          32'd0);
        check("arst_valid",   32'(sample_valid), 32'd0);
        check("arst_sample",  sample_out,        32'd0);
        check("arst_drop",    32'(dropped_cnt),  32'd0);
        check("arst_core",    32'({u01_rst, u01_en, u01_seed}), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stay_idle", 32'({busy, running, u01_rst, u01_en}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
